frame_capture_ctrl: RTL and testbench
=====================================

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320; pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 240; lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 17; write-address width, which SHALL be at least clog2(H_ACTIVE*V_ACTIVE).
REQ-004 SHALL have port pclk  in  1  camera pixel clock; the only clock.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port config_done  in  1  sensor register configuration complete.
REQ-007 SHALL have port vsync  in  1  frame sync, high during vertical blanking.
REQ-008 SHALL have port href  in  1  line valid.
REQ-009 SHALL have port pix_valid  in  1  one-cycle strobe, one pixel on pixel_data.
REQ-010 SHALL have port pixel_data  in  8  pixel byte.
REQ-011 SHALL have port cmd_start  in  1  start request, level-sampled.
REQ-012 SHALL have port cmd_stop  in  1  stop request, level-sampled.
REQ-013 SHALL have port mode_cont  in  1  1 = continuous capture, 0 = single shot.
REQ-014 SHALL have port wr_en  out  1  frame-buffer write strobe.
REQ-015 SHALL have port wr_addr  out  ADDR_W  frame-buffer write address.
REQ-016 SHALL have port wr_data  out  8  frame-buffer write data.
REQ-017 SHALL have port busy  out  1  high in any state except IDLE.
REQ-018 SHALL have port frame_done  out  1  one-cycle pulse at the end of each captured frame.
REQ-019 SHALL have port frame_count  out  8  count of completed frames.
REQ-020 SHALL have port err_short  out  1  sticky flag: a frame ended with fewer than H_ACTIVE*V_ACTIVE pixels.
REQ-021 SHALL have port err_ovf  out  1  sticky flag: a pixel arrived after the frame buffer was full.
REQ-022 SHALL have port err_abort  out  1  sticky flag: config_done dropped during ARM or CAPTURE.

Function
REQ-023 SHALL register vsync once (vsync_q) and derive edges from it: vs_fall = vsync_q & ~vsync, vs_rise = ~vsync_q & vsync.
REQ-024 SHALL implement states IDLE, ARM, CAPTURE and DONE; all outputs SHALL be registered.
REQ-025 IDLE SHALL go to ARM when cmd_start & config_done & ~cmd_stop; cmd_start without config_done SHALL be ignored; if start and stop are both high, stop SHALL win.
REQ-026 ARM SHALL go to CAPTURE on vs_fall, clearing the pixel counter to 0; cmd_stop or ~config_done in ARM SHALL return to IDLE.
REQ-027 In CAPTURE, each cycle with pix_valid & href & (count < H_ACTIVE*V_ACTIVE) SHALL produce wr_en=1, wr_addr=count and wr_data=pixel_data on the next cycle, and SHALL increment count.
REQ-028 wr_en SHALL be high exactly one cycle per accepted pixel; wr_addr SHALL be count zero-extended to ADDR_W.
REQ-029 pix_valid while count = H_ACTIVE*V_ACTIVE SHALL produce no write, SHALL set err_ovf, and count SHALL saturate.
REQ-030 pix_valid while href=0 SHALL be ignored.
REQ-031 cmd_stop in CAPTURE SHALL set stop_pending and SHALL NOT truncate the frame.
REQ-032 vs_rise in CAPTURE SHALL go to DONE.
REQ-033 ~config_done in CAPTURE SHALL abort to IDLE with no frame_done and SHALL set err_abort.
REQ-034 DONE SHALL last exactly one cycle and SHALL assert frame_done.
REQ-035 DONE SHALL increment frame_count modulo 256 (255 -> 0).
REQ-036 DONE SHALL set err_short if count < H_ACTIVE*V_ACTIVE.
REQ-037 DONE SHALL go to ARM if mode_cont & ~stop_pending & ~cmd_stop; otherwise it SHALL go to IDLE and clear stop_pending.
REQ-038 A vs_fall and pix_valid in the same cycle in ARM SHALL NOT write that pixel.
REQ-039 Error flags SHALL clear only on reset or on a start accepted in IDLE.

Reset
REQ-040 reset_n low SHALL, asynchronously, force IDLE, clear count, clear stop_pending, set vsync_q=1, and drive wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_count=0, err_short=0, err_ovf=0, err_abort=0.
REQ-041 Reset asserted mid-CAPTURE SHALL take effect immediately with no further writes; after release the block SHALL wait for a new cmd_start.

Verification
REQ-042 Single shot, 4x2 frame (H_ACTIVE=4, V_ACTIVE=2), cmd_start, then vsync fall and 8 pixels 0x10..0x17, then vsync rise -> writes to addresses 0..7 with matching data, one frame_done pulse, frame_count=1, return to IDLE, err flags 0.
REQ-043 Continuous mode, 3 frames, cmd_stop during frame 2 -> frame 2 completes in full, frame_count=2, IDLE, no writes during frame 3.
REQ-044 10 pixels into a 4x2 frame -> exactly 8 writes, err_ovf=1, err_short=0.
REQ-045 Frame ending after 5 of 8 pixels -> frame_done pulse, err_short=1, frame_count increments.
REQ-046 config_done dropped after 3 writes -> IDLE, err_abort=1, no frame_done, frame_count unchanged.
REQ-047 reset_n pulsed low between pclk edges mid-CAPTURE -> wr_en=0 and busy=0 before the next edge; cmd_start with config_done=0 -> stays IDLE.

Source files
------------

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: captures one camera frame (or a continuous stream of
// frames) from an 8-bit pixel bus into a linear frame buffer. It arms on a
// start command, begins on the falling edge of vsync, writes every pixel
// qualified by href, and closes the frame on the rising edge of vsync.
// It also keeps a frame counter and sticky error flags for short frames,
// buffer overflow and configuration loss.
module frame_capture_ctrl #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              config_done,
  input  logic              vsync,
  input  logic              href,
  input  logic              pix_valid,
  input  logic [7:0]        pixel_data,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              mode_cont,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              err_short,
  output logic              err_ovf,
  output logic              err_abort
);

  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  // The pixel counter must be able to hold FRAME_PIX itself (the saturated
  // "buffer full" value), which can need one bit more than the address.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_PIX_C = CNT_W'(FRAME_PIX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              vsync_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              stop_pend_q, stop_pend_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              err_short_q, err_short_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_abort_q, err_abort_d;

  logic              vs_fall;
  logic              vs_rise;
  logic              pix_ok;
  logic              buf_full;

  // Frame sync edges come from a single registered copy of vsync.
  assign vs_fall  = vsync_q & ~vsync;
  assign vs_rise  = ~vsync_q & vsync;
  // A pixel only counts when the line is valid.
  assign pix_ok   = pix_valid & href;
  assign buf_full = (count_q == FRAME_PIX_C);

  // Capture FSM register.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus next values of every registered output.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    stop_pend_d   = stop_pend_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_count_d = frame_count_q;
    err_short_d   = err_short_q;
    err_ovf_d     = err_ovf_q;
    err_abort_d   = err_abort_q;

    unique case (state_q)
      ST_IDLE: begin
        // Stop wins over start; start without a configured sensor is ignored.
        if (cmd_start & config_done & ~cmd_stop) begin
          state_d     = ST_ARM;
          err_short_d = 1'b0;
          err_ovf_d   = 1'b0;
          err_abort_d = 1'b0;
        end
      end

      ST_ARM: begin
        // Any pixel arriving here, even with the frame-start edge, is dropped.
        if (cmd_stop | ~config_done) begin
          state_d = ST_IDLE;
          if (!config_done) begin
            err_abort_d = 1'b1;
          end
        end else if (vs_fall) begin
          state_d = ST_CAPTURE;
          count_d = '0;
        end
      end

      ST_CAPTURE: begin
        if (!config_done) begin
          // Sensor lost its configuration: abandon the frame silently.
          state_d     = ST_IDLE;
          err_abort_d = 1'b1;
        end else begin
          // A stop only prevents re-arming; the current frame runs to its end.
          if (cmd_stop) begin
            stop_pend_d = 1'b1;
          end
          if (pix_ok) begin
            if (buf_full) begin
              err_ovf_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = count_q[ADDR_W-1:0];
              wr_data_d = pixel_data;
              count_d   = count_q + CNT_W'(1);
            end
          end
          if (vs_rise) begin
            // Frame statistics are updated on entry to DONE so that they
            // appear on the outputs together with the frame_done pulse.
            state_d       = ST_DONE;
            frame_count_d = frame_count_q + 8'd1;
            if (count_d < FRAME_PIX_C) begin
              err_short_d = 1'b1;
            end
          end
        end
      end

      ST_DONE: begin
        if (mode_cont & ~stop_pend_q & ~cmd_stop) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A pending stop never outlives a return to IDLE.
    if (state_d == ST_IDLE) begin
      stop_pend_d = 1'b0;
    end

    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  // Datapath, status and output registers.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q       <= 1'b1;
      count_q       <= '0;
      stop_pend_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_short_q   <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_abort_q   <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      count_q       <= count_d;
      stop_pend_q   <= stop_pend_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_short_q   <= err_short_d;
      err_ovf_q     <= err_ovf_d;
      err_abort_q   <= err_abort_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign err_short   = err_short_q;
  assign err_ovf     = err_ovf_q;
  assign err_abort   = err_abort_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl on a 4x2 frame. Stimulus pushes expected
// writes and frame_done events into queues; a monitor pops and compares.
module tb_frame_capture_ctrl;

  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 3;

  logic          pclk = 1'b0;
  logic          reset_n;
  logic          config_done;
  logic          vsync;
  logic          href;
  logic          pix_valid;
  logic [7:0]    pixel_data;
  logic          cmd_start;
  logic          cmd_stop;
  logic          mode_cont;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic          err_short;
  logic          err_ovf;
  logic          err_abort;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  typedef struct packed {
    logic [7:0] cnt;
    logic       sh;
    logic       ov;
  } fd_t;

  wr_t wr_q[$];
  fd_t fd_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  frame_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .pclk(pclk), .reset_n(reset_n), .config_done(config_done),
    .vsync(vsync), .href(href), .pix_valid(pix_valid),
    .pixel_data(pixel_data), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .mode_cont(mode_cont), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .err_short(err_short), .err_ovf(err_ovf),
    .err_abort(err_abort)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; config_done = 1'b1; vsync = 1'b1; href = 1'b0;
    pix_valid = 1'b0; pixel_data = 8'h00; cmd_start = 1'b0;
    cmd_stop = 1'b0; mode_cont = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic start_cmd();
    cmd_start = 1'b1;
    cyc(1);
    cmd_start = 1'b0;
  endtask

  // One frame: vsync low, npix strobed pixels with an href gap (and an
  // ignored href=0 strobe) after every line, then vsync high again.
  task automatic send_frame(input int npix, input logic [7:0] base,
                            input bit capture, input int stop_at);
    vsync = 1'b0;
    cyc(2);
    for (int i = 0; i < npix; i++) begin
      href = 1'b1; pix_valid = 1'b1; pixel_data = base + 8'(i);
      cmd_stop = (i == stop_at);
      if (capture && i < H * V)
        wr_q.push_back('{addr: AW'(i), data: base + 8'(i)});
      cyc(1);
      pix_valid = 1'b0; cmd_stop = 1'b0;
      cyc(1);
      if ((i % H) == H - 1) begin
        href = 1'b0; pix_valid = 1'b1; pixel_data = 8'hEE;
        cyc(1);
        pix_valid = 1'b0;
        cyc(1);
      end
    end
    href = 1'b0; pix_valid = 1'b0;
    cyc(2);
    vsync = 1'b1;
    cyc(3);
  endtask

  // Monitor: every write and every frame_done must match the next expectation.
  initial begin
    wr_t e;
    fd_t f;
    forever begin
      @(negedge pclk);
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got addr=%0d data=%0h, expected no write (t=%0t)",
                   wr_addr, wr_data, $time);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_frame_done: got pulse, expected none (t=%0t)", $time);
        end else begin
          f = fd_q.pop_front();
          chk("done_frame_count", 32'(frame_count), 32'(f.cnt));
          chk("done_err_short", 32'(err_short), 32'(f.sh));
          chk("done_err_ovf", 32'(err_ovf), 32'(f.ov));
        end
      end
    end
  end

  task automatic chk_drained(input string tag);
    chk({tag, "_writes_left"}, 32'(wr_q.size()), 32'd0);
    chk({tag, "_done_left"}, 32'(fd_q.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; config_done = 1'b1; vsync = 1'b1; href = 1'b0;
    pix_valid = 1'b0; pixel_data = 8'h00; cmd_start = 1'b0;
    cmd_stop = 1'b0; mode_cont = 1'b0;
    #2;
    // Reset state.
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_errs", 32'({err_short, err_ovf, err_abort}), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);

    // Single shot, full frame.
    do_reset();
    start_cmd();
    chk("ss_busy_armed", 32'(busy), 32'd1);
    fd_q.push_back('{cnt: 8'd1, sh: 1'b0, ov: 1'b0});
    send_frame(8, 8'h10, 1'b1, -1);
    chk("ss_busy_idle", 32'(busy), 32'd0);
    chk("ss_frame_count", 32'(frame_count), 32'd1);
    chk("ss_errs", 32'({err_short, err_ovf, err_abort}), 32'd0);
    send_frame(8, 8'h40, 1'b0, -1);
    chk_drained("ss");

    // Continuous mode, stop requested during frame 2.
    do_reset();
    mode_cont = 1'b1;
    start_cmd();
    fd_q.push_back('{cnt: 8'd1, sh: 1'b0, ov: 1'b0});
    send_frame(8, 8'h20, 1'b1, -1);
    chk("cont_busy_rearm", 32'(busy), 32'd1);
    fd_q.push_back('{cnt: 8'd2, sh: 1'b0, ov: 1'b0});
    send_frame(8, 8'h30, 1'b1, 3);
    send_frame(8, 8'h60, 1'b0, -1);
    chk("cont_frame_count", 32'(frame_count), 32'd2);
    chk("cont_busy", 32'(busy), 32'd0);
    mode_cont = 1'b0;
    chk_drained("cont");

    // Overflow: 10 pixels into an 8-pixel buffer.
    do_reset();
    start_cmd();
    fd_q.push_back('{cnt: 8'd1, sh: 1'b0, ov: 1'b1});
    send_frame(10, 8'h70, 1'b1, -1);
    chk("ovf_err_ovf", 32'(err_ovf), 32'd1);
    chk("ovf_err_short", 32'(err_short), 32'd0);
    chk_drained("ovf");

    // Short frame: 5 of 8 pixels.
    do_reset();
    start_cmd();
    fd_q.push_back('{cnt: 8'd1, sh: 1'b1, ov: 1'b0});
    send_frame(5, 8'h80, 1'b1, -1);
    chk("short_err_short", 32'(err_short), 32'd1);
    chk("short_frame_count", 32'(frame_count), 32'd1);
    // An accepted start clears the sticky flags; stop in ARM returns to IDLE.
    start_cmd();
    chk("short_err_cleared", 32'(err_short), 32'd0);
    cmd_stop = 1'b1;
    cyc(1);
    cmd_stop = 1'b0;
    chk("arm_stop_busy", 32'(busy), 32'd0);
    chk("arm_stop_count", 32'(frame_count), 32'd1);
    chk_drained("short");

    // Abort: config_done drops after 3 writes.
    do_reset();
    start_cmd();
    vsync = 1'b0;
    cyc(2);
    href = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1; pixel_data = 8'h90 + 8'(i);
      wr_q.push_back('{addr: AW'(i), data: 8'h90 + 8'(i)});
      cyc(1);
      pix_valid = 1'b0;
      cyc(1);
    end
    config_done = 1'b0; pix_valid = 1'b1; pixel_data = 8'hA5;
    cyc(1);
    pix_valid = 1'b0; href = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err_abort", 32'(err_abort), 32'd1);
    vsync = 1'b1;
    cyc(3);
    chk("abort_frame_count", 32'(frame_count), 32'd0);
    // Start while the sensor is unconfigured is ignored.
    start_cmd();
    chk("nocfg_busy", 32'(busy), 32'd0);
    cyc(2);
    chk("nocfg_busy_later", 32'(busy), 32'd0);
    chk("nocfg_err_abort_kept", 32'(err_abort), 32'd1);
    config_done = 1'b1;
    chk_drained("abort");

    // Asynchronous reset in the middle of a capture.
    do_reset();
    start_cmd();
    vsync = 1'b0;
    cyc(2);
    href = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pix_valid = 1'b1; pixel_data = 8'hC0 + 8'(i);
      wr_q.push_back('{addr: AW'(i), data: 8'hC0 + 8'(i)});
      cyc(1);
    end
    pixel_data = 8'hAA;
    @(negedge pclk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_wr_en", 32'(wr_en), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    cyc(3);
    reset_n = 1'b1; pix_valid = 1'b0; href = 1'b0; vsync = 1'b1;
    cyc(3);
    send_frame(8, 8'hD0, 1'b0, -1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_frame_count", 32'(frame_count), 32'd0);
    chk_drained("async");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
